// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared opcodes, exception codes and FSM state type for the memory-access stage
package mem_pkg;

  // ramOp encodings
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_LD  = 4'd9;
  localparam logic [3:0] OP_SD  = 4'd10;

  // exception codes reported to CP0
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_BUS  = 32'h0000_0007;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // access size in bytes; 0 means "no memory access" (NOP, unknown, or LD/SD on a 32-bit bus)
  function automatic logic [3:0] op_bytes(input logic [3:0] op, input int data_w);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_bytes = 4'd1;
      OP_LH, OP_LHU, OP_SH: op_bytes = 4'd2;
      OP_LW, OP_SW:         op_bytes = 4'd4;
      OP_LD, OP_SD:         op_bytes = (data_w == 64) ? 4'd8 : 4'd0;
      default:              op_bytes = 4'd0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SD);
  endfunction

  function automatic logic op_is_signed(input logic [3:0] op);
    op_is_signed = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LD);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-enable generation, store replication and load extraction/extension
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int LANE_W = $clog2(NB)
) (
  input  logic [3:0]        st_op,
  input  logic [LANE_W-1:0] st_lane,
  input  logic [DATA_W-1:0] st_data,
  input  logic [3:0]        ld_op,
  input  logic [LANE_W-1:0] ld_lane,
  input  logic [DATA_W-1:0] rdata,
  output logic [NB-1:0]     be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ld_data
);

  logic [3:0]        st_bytes;
  logic [3:0]        ld_bytes;
  logic [NB-1:0]     mask;
  logic [DATA_W-1:0] shifted;
  logic              fill;

  assign st_bytes = op_bytes(st_op, DATA_W);
  // stores never produce load data
  assign ld_bytes = op_is_store(ld_op) ? 4'd0 : op_bytes(ld_op, DATA_W);
  assign shifted  = rdata >> {ld_lane, 3'b000};

  // contiguous mask of the access size, moved up to the addressed lane
  always_comb begin
    mask = '0;
    for (int i = 0; i < NB; i++) mask[i] = (i < int'(st_bytes));
    be = mask << st_lane;
  end

  // replicate the store operand across every lane so any lane offset sees it
  always_comb begin
    wdata = '0;
    case (st_bytes)
      4'd1: for (int i = 0; i < NB; i++) wdata[i*8 +: 8] = st_data[7:0];
      4'd2: for (int i = 0; i < NB / 2; i++) wdata[i*16 +: 16] = st_data[15:0];
      4'd4: for (int i = 0; i < DATA_W / 32; i++) wdata[i*32 +: 32] = st_data[31:0];
      4'd8: wdata = st_data;
      default: wdata = '0;
    endcase
  end

  // pick the addressed lanes and sign- or zero-extend to the full width
  always_comb begin
    ld_data = '0;
    fill    = 1'b0;
    case (ld_bytes)
      4'd1: begin
        fill          = op_is_signed(ld_op) & shifted[7];
        ld_data       = {DATA_W{fill}};
        ld_data[7:0]  = shifted[7:0];
      end
      4'd2: begin
        fill          = op_is_signed(ld_op) & shifted[15];
        ld_data       = {DATA_W{fill}};
        ld_data[15:0] = shifted[15:0];
      end
      4'd4: begin
        fill          = op_is_signed(ld_op) & shifted[31];
        ld_data       = {DATA_W{fill}};
        ld_data[31:0] = shifted[31:0];
      end
      4'd8: ld_data = shifted;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - registered bus-master MEM stage with alignment checks, timeout and stall
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic [3:0]          ramOp_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   storeData_i,
  input  logic [31:0]         exceptionType_i,
  input  logic                flush_i,
  input  logic                advance_i,
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic                bus_err,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic [DATA_W-1:0]   load_data_o,
  output logic [31:0]         exceptionType_o,
  output logic [ADDR_W-1:0]   badvaddr_o,
  output logic                pauseRequest
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              killed;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] ld_q;
  logic              err_q;

  logic [3:0]        nbytes;
  logic              is_mem;
  logic              misaligned;
  logic              exc_in;
  logic              launch;
  logic              finish;
  logic              kill_now;
  logic [NB-1:0]     be_next;
  logic [DATA_W-1:0] wdata_next;
  logic [DATA_W-1:0] ld_ext;

  assign nbytes   = op_bytes(ramOp_i, DATA_W);
  assign is_mem   = (nbytes != 4'd0);
  assign exc_in   = (exceptionType_i != 32'd0);
  assign launch   = (state == ST_IDLE) && valid_i && is_mem && !exc_in && !misaligned && !flush_i;
  // the last REQ cycle: either the ack arrives or the counter is about to hit TIMEOUT
  assign finish   = bus_ack || (cnt == CNT_LAST);
  assign kill_now = killed || flush_i;

  // stall while an access is launching or in flight
  assign pauseRequest = (state == ST_REQ) || launch;

  // natural alignment check for the requested access size
  always_comb begin
    misaligned = 1'b0;
    case (nbytes)
      4'd2:    misaligned = addr_i[0];
      4'd4:    misaligned = |addr_i[1:0];
      4'd8:    misaligned = |addr_i[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .st_op   (ramOp_i),
    .st_lane (addr_i[LANE_W-1:0]),
    .st_data (storeData_i),
    .ld_op   (op_q),
    .ld_lane (addr_q[LANE_W-1:0]),
    .rdata   (bus_rdata),
    .be      (be_next),
    .wdata   (wdata_next),
    .ld_data (ld_ext)
  );

  // access FSM: launch, hold the bus stable until ack/timeout, then hold the result until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      killed    <= 1'b0;
      op_q      <= OP_NOP;
      addr_q    <= '0;
      ld_q      <= '0;
      err_q     <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state     <= ST_REQ;
            cnt       <= '0;
            killed    <= 1'b0;
            op_q      <= ramOp_i;
            addr_q    <= addr_i;
            ld_q      <= '0;
            err_q     <= 1'b0;
            bus_req   <= 1'b1;
            bus_we    <= op_is_store(ramOp_i);
            bus_be    <= be_next;
            bus_addr  <= {addr_i[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            bus_wdata <= op_is_store(ramOp_i) ? wdata_next : '0;
          end
        end
        ST_REQ: begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          killed <= kill_now;
          if (finish) begin
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            bus_be  <= '0;
            // a flushed access runs to completion on the bus but its result is dropped
            if (kill_now) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_DONE;
              if (bus_ack) begin
                ld_q  <= ld_ext;
                err_q <= bus_err;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          if (advance_i || flush_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // result mux: held bus result in DONE, immediate pass-through/alignment exceptions in IDLE
  always_comb begin
    load_data_o     = '0;
    exceptionType_o = '0;
    badvaddr_o      = '0;
    if (state == ST_DONE) begin
      load_data_o = ld_q;
      if (err_q) begin
        exceptionType_o = EXC_BUS;
        badvaddr_o      = addr_q;
      end
    end else if ((state == ST_IDLE) && valid_i) begin
      if (exc_in) begin
        exceptionType_o = exceptionType_i;
      end else if (is_mem && misaligned) begin
        exceptionType_o = op_is_store(ramOp_i) ? EXC_ADES : EXC_ADEL;
        badvaddr_o      = addr_i;
      end
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-access pipeline stage that replaces the single-cycle MEM pass-through with a registered bus master. It checks alignment, drives byte-lane enables and store-data replication, and runs a request/acknowledge handshake to the data bus with a timeout. It sign- or zero-extends load data and stalls the pipeline until the access completes. It sits between EX/MEM and MEM/WB and reports its exception codes to the CP0 exception logic.

## Interface
Parameters:
- DATA_W, 32: bus and register data width, 32 or 64.
- ADDR_W, 32: address width.
- TIMEOUT, 255: maximum number of REQ cycles without bus_ack before a bus error is raised; must be at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- valid_i  in  1  the stage holds a live instruction.
- ramOp_i  in  4  memory opcode; encodings are in the shared package.
- addr_i  in  ADDR_W  effective address.
- storeData_i  in  DATA_W  unshifted store operand.
- exceptionType_i  in  32  exception code from earlier stages; nonzero suppresses the access.
- flush_i  in  1  pipeline flush.
- advance_i  in  1  MEM/WB accepts this stage's result this cycle.
- bus_req  out  1  bus request.
- bus_we  out  1  write strobe.
- bus_be  out  DATA_W/8  byte enables.
- bus_addr  out  ADDR_W  word-aligned address (low lane bits zero).
- bus_wdata  out  DATA_W  lane-replicated store data.
- bus_ack  in  1  transfer complete.
- bus_err  in  1  bus error; sampled only together with bus_ack.
- bus_rdata  in  DATA_W  read data; sampled only together with bus_ack.
- load_data_o  out  DATA_W  extended load result.
- exceptionType_o  out  32  final exception code.
- badvaddr_o  out  ADDR_W  faulting address.
- pauseRequest  out  1  stall request to the pipeline controller.

## Operation
- Opcodes: NOP, LB, LBU, LH, LHU, LW, SB, SH, SW. LD and SD exist only when DATA_W=64.
- Misalignment:
  - Halfword: addr[0] is nonzero.
  - Word: addr[1:0] is nonzero.
  - Doubleword: addr[2:0] is nonzero.
- Exception priority:
  1. exceptionType_i is nonzero: it passes through unchanged.
  2. Misaligned load gives 0x4; misaligned store gives 0x5. badvaddr_o = addr_i.
  3. Bus error or timeout gives 0x7. badvaddr_o = addr_i.
  4. Otherwise exceptionType_o = 0.
- Any exception from rules 1 or 2 issues no bus access and raises no pauseRequest.
- Lane index = addr_i[log2(DATA_W/8)-1:0].
  - bus_be has ones only on the bytes being accessed.
  - Stores replicate byte, halfword and word data across all lanes.
- Loads select the addressed lanes from bus_rdata. LB, LH and (64-bit) LW sign-extend; LBU and LHU zero-extend.
- FSM states: IDLE, REQ, DONE.
  - IDLE to REQ: valid_i, ramOp_i is not NOP, no exception, and flush_i is low. Bus outputs are registered on this edge. pauseRequest = 1 combinationally in that IDLE cycle.
  - REQ: bus_req = 1; all bus_* outputs stay stable. A timeout counter increments every cycle.
  - REQ to DONE: bus_ack = 1 (load data captured; bus_err captured), or the counter reaches TIMEOUT (error flagged; bus_req drops).
  - DONE: pauseRequest = 0; load_data_o and exceptionType_o are held. DONE to IDLE on advance_i or flush_i.
- flush_i during REQ: the transaction is never abandoned. A sticky "killed" flag is set. On completion the FSM goes directly to IDLE, discards the result, and does not raise the bus error.
- pauseRequest = 1 in REQ, and in IDLE while an access is about to launch.

## Timing
- Minimum access: bus_req rises in cycle 1. bus_ack arriving in cycle 1 puts the FSM in DONE in cycle 2. pauseRequest is high for cycles 0 and 1.
- Latency is 2 + N cycles for an ack delay of N, capped at TIMEOUT+1 cycles.
- Reset values (asynchronous):
  - FSM = IDLE, counter = 0, killed = 0.
  - bus_req, bus_we, bus_be, bus_addr, bus_wdata = 0.
  - load_data_o, exceptionType_o, badvaddr_o = 0.
  - pauseRequest = 0.
- Reset during REQ drops bus_req immediately; the bus must tolerate an abandoned request.
- bus_ack seen outside REQ is ignored.
- Counter wrap: the counter saturates at TIMEOUT and never wraps.

## Structure
- Shared package mem_pkg holds:
  - the ramOp encodings;
  - the exception codes 0x4, 0x5 and 0x7;
  - the FSM state typedef.
- One natural sub-module, mem_lane_align (combinational):
  - builds bus_be and replicates store data;
  - performs load extraction and extension.
- The FSM and timeout counter live in the top module.

## Test plan
- DATA_W=32, LB at addr 0x1003, ack after 2 cycles with rdata 0x80FF_FF12: bus_be=4'b1000, load_data_o=0xFFFF_FF80, pauseRequest high for 4 cycles.
- SH at addr 0x2002 with data 0x0000_BEEF: bus_be=4'b1100, bus_wdata=0xBEEF_BEEF, bus_we=1.
- LW at addr 0x1001: no bus_req, exceptionType_o=0x4, badvaddr_o=0x1001, pauseRequest=0.
- TIMEOUT=4, no ack: bus_req high for 4 cycles, then DONE with exceptionType_o=0x7.
- flush_i asserted in the second REQ cycle, ack in the third: the FSM returns to IDLE, no exception is reported, and the next LW proceeds normally.
- DATA_W=64, LW at addr 0x4 with rdata 0x8000_0000_0000_0000: load_data_o=0xFFFF_FFFF_8000_0000. Reset asserted mid-REQ drops bus_req the same cycle.
